// File: rtl/wallace_mul_reducer_pkg.sv
// Shared types and sizing constants for the M-extension multiplier front end.
package m_ext_pkg;

  // Encoding matches funct3[1:0] of the M-extension multiply ops.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  localparam int unsigned MUL_PP_ROWS = 34;
  localparam int unsigned MUL_S1_ROWS = 8;
  localparam int unsigned MUL_PROD_W  = 64;

endpackage

// File: rtl/csa_3_2.sv
// 3:2 carry-save compressor; the carry row comes out already weighted (<<1)
// and truncated to W bits.
module csa_3_2 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  // Sum is the bitwise parity; carry is the majority moved up one weight.
  always_comb begin
    s = x ^ y ^ z;
    c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
  end

endmodule

// File: rtl/wallace_mul_reducer.sv
// Two-stage pipelined Wallace reduction of signed 33x33 partial products
// into a redundant (sum, carry) pair, with valid/ready flow control and flush.
module wallace_mul_reducer
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  mul_op_t             op_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  output logic                valid_o,
  input  logic                ready_i,
  output mul_op_t             op_o,
  output logic [2*XLEN-1:0]   sum_o,
  output logic [2*XLEN-1:0]   carry_o
);

  localparam int unsigned P = 2 * XLEN;

  logic [XLEN:0] a_ext;
  logic [XLEN:0] b_ext;
  logic [P-1:0]  a_sx;
  logic [P-1:0]  pp [MUL_PP_ROWS];
  logic [P-1:0]  l1 [23];
  logic [P-1:0]  l2 [16];
  logic [P-1:0]  l3 [11];
  logic [P-1:0]  s1_rows_d [MUL_S1_ROWS];
  logic [P-1:0]  s1_rows_q [MUL_S1_ROWS];
  logic [P-1:0]  l5 [6];
  logic [P-1:0]  l6 [4];
  logic [P-1:0]  l7 [3];
  logic [P-1:0]  sum_d, sum_q;
  logic [P-1:0]  carry_d, carry_q;
  mul_op_t       s1_op_d, s1_op_q;
  mul_op_t       op_d, op_q;
  logic          s1_valid_d, s1_valid_q;
  logic          valid_d, valid_q;
  logic          advance_out, advance_s1, load_s1, load_out;

  // Operand extension and partial-product generation (rows 0..33).
  always_comb begin
    a_ext = (op_i == MULH || op_i == MULHSU) ? {rs1_i[XLEN-1], rs1_i} : {1'b0, rs1_i};
    b_ext = (op_i == MULH) ? {rs2_i[XLEN-1], rs2_i} : {1'b0, rs2_i};
    a_sx  = {{(P-XLEN-1){a_ext[XLEN]}}, a_ext};
    for (int unsigned i = 0; i < XLEN; i++) begin
      pp[i] = b_ext[i] ? (a_sx << i) : '0;
    end
    // Negative weight of b[32]: -a<<32 == (~a)<<32 + 1<<32, split over two rows.
    pp[XLEN]         = b_ext[XLEN] ? {~a_ext[XLEN-1:0], {XLEN{1'b0}}} : '0;
    pp[XLEN+1]       = '0;
    pp[XLEN+1][XLEN] = b_ext[XLEN];
  end

  // Stage 1 reduction: 34 -> 23 -> 16 -> 11 -> 8.
  for (genvar g = 0; g < 11; g++) begin : g_l1
    csa_3_2 #(.W(P)) u_csa (.x(pp[3*g]), .y(pp[3*g+1]), .z(pp[3*g+2]), .s(l1[2*g]), .c(l1[2*g+1]));
  end
  assign l1[22] = pp[33];

  for (genvar g = 0; g < 7; g++) begin : g_l2
    csa_3_2 #(.W(P)) u_csa (.x(l1[3*g]), .y(l1[3*g+1]), .z(l1[3*g+2]), .s(l2[2*g]), .c(l2[2*g+1]));
  end
  assign l2[14] = l1[21];
  assign l2[15] = l1[22];

  for (genvar g = 0; g < 5; g++) begin : g_l3
    csa_3_2 #(.W(P)) u_csa (.x(l2[3*g]), .y(l2[3*g+1]), .z(l2[3*g+2]), .s(l3[2*g]), .c(l3[2*g+1]));
  end
  assign l3[10] = l2[15];

  for (genvar g = 0; g < 3; g++) begin : g_l4
    csa_3_2 #(.W(P)) u_csa (.x(l3[3*g]), .y(l3[3*g+1]), .z(l3[3*g+2]), .s(s1_rows_d[2*g]), .c(s1_rows_d[2*g+1]));
  end
  assign s1_rows_d[6] = l3[9];
  assign s1_rows_d[7] = l3[10];

  // Stage 2 reduction: 8 -> 6 -> 4 -> 3 -> 2.
  for (genvar g = 0; g < 2; g++) begin : g_l5
    csa_3_2 #(.W(P)) u_csa (.x(s1_rows_q[3*g]), .y(s1_rows_q[3*g+1]), .z(s1_rows_q[3*g+2]), .s(l5[2*g]), .c(l5[2*g+1]));
  end
  assign l5[4] = s1_rows_q[6];
  assign l5[5] = s1_rows_q[7];

  for (genvar g = 0; g < 2; g++) begin : g_l6
    csa_3_2 #(.W(P)) u_csa (.x(l5[3*g]), .y(l5[3*g+1]), .z(l5[3*g+2]), .s(l6[2*g]), .c(l6[2*g+1]));
  end

  csa_3_2 #(.W(P)) u_csa_l7 (.x(l6[0]), .y(l6[1]), .z(l6[2]), .s(l7[0]), .c(l7[1]));
  assign l7[2] = l6[3];

  csa_3_2 #(.W(P)) u_csa_l8 (.x(l7[0]), .y(l7[1]), .z(l7[2]), .s(sum_d), .c(carry_d));

  // Pipeline control: each stage advances when its successor is empty or draining.
  always_comb begin
    advance_out = !valid_q || ready_i;
    advance_s1  = !s1_valid_q || advance_out;
    load_s1     = valid_i && advance_s1 && !flush_i;
    load_out    = advance_out && s1_valid_q && !flush_i;
    s1_op_d     = op_i;
    op_d        = s1_op_q;
    s1_valid_d  = s1_valid_q;
    valid_d     = valid_q;
    if (advance_s1) s1_valid_d = valid_i;
    if (advance_out) valid_d = s1_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      valid_d    = 1'b0;
    end
  end

  // Pipeline registers; data loads only on advance, valids follow the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      s1_op_q    <= MUL;
      op_q       <= MUL;
      sum_q      <= '0;
      carry_q    <= '0;
      for (int unsigned i = 0; i < MUL_S1_ROWS; i++) s1_rows_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      valid_q    <= valid_d;
      if (load_s1) begin
        s1_op_q   <= s1_op_d;
        s1_rows_q <= s1_rows_d;
      end
      if (load_out) begin
        op_q    <= op_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  assign ready_o = advance_s1;
  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: doc/wallace_mul_reducer.md
# wallace_mul_reducer

Pipelined front end of the M-extension multiplier. Takes two 32-bit register operands and a multiply op, forms signed 33×33 partial products, and reduces them through two registered Wallace (3:2 CSA) stages into a redundant pair (`sum_o`, `carry_o`). The 64-bit carry-lookahead adder directly downstream adds this pair. The block provides valid/ready flow control and a flush.

## Interface
Parameters:
- `XLEN`, 32, operand width. Product width is 2·XLEN.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush_i` in 1: synchronous kill of all in-flight ops.
- `valid_i` in 1: input op valid.
- `ready_o` out 1: block accepts the op this cycle.
- `op_i` in 2: `mul_op_t` (funct3[1:0]): MUL=00, MULH=01, MULHSU=10, MULHU=11.
- `rs1_i` in XLEN: multiplicand.
- `rs2_i` in XLEN: multiplier.
- `valid_o` out 1: output pair valid.
- `ready_i` in 1: downstream accepts the pair.
- `op_o` out 2: op carried alongside the data.
- `sum_o` out 2·XLEN: redundant sum row.
- `carry_o` out 2·XLEN: redundant carry row, already aligned. `sum_o + carry_o` mod 2^64 equals the product.

## Operation
- Operand extension to 33 bits:
  - `a` is sign-extended for MULH/MULHSU; `b` is sign-extended for MULH only.
  - Otherwise both are zero-extended.
- Rows 0..31: `b[i] ? a_ext<<i : 0`, sign-extended to 64 bits.
- Row 32 (sign weight): `b[32] ? (~a_ext)<<32 : 0`, restricted to bits 32..63.
- Row 33 (correction): bit 32 = `b[32]`, all other bits 0.
- Resulting 34 rows, all mod 2^64.
- Stage 1 (combinational, then registered): 3:2 levels 34→23→16→11→8. Register 8 rows.
- Stage 2: 8→6→4→3→2. Register `sum_o`/`carry_o`.
- Every CSA carry is shifted left by 1. Bit 64 is discarded.
- `op_o` travels with the data; the downstream adder selects the low or high half.

## Timing
- Latency is exactly 2 cycles, accept edge to `valid_o`. With no stalls the block sustains 1 op/cycle.
- Input handshake: an op is accepted on an edge where `valid_i && ready_o`.
- Output handshake: a pair is consumed on an edge where `valid_o && ready_i`.
- `ready_o = !s1_valid || !valid_o || ready_i`. The pipeline advances as a whole; each stage holds when its successor is full and not draining.
- Stall: while `valid_o && !ready_i`, `sum_o`, `carry_o` and `op_o` are held bit-stable.
- `flush_i`:
  - Clears `s1_valid` and `valid_o` on the next edge.
  - Any op presented in the same cycle is dropped, even if `ready_o` is high.
  - `ready_o` is 1 the following cycle.
- Reset values: `valid_o=0`, `s1_valid=0`, `sum_o=0`, `carry_o=0`, `op_o=MUL`. `ready_o` reads 1 in the cycle after reset.
- Reset mid-operation behaves the same as flush; no partial op survives.
- Priority: `rst` > `flush_i` > handshake.
- Data registers update only on advance. Valid registers follow the handshake.

## Structure
- Package `m_ext_pkg`:
  - `mul_op_t` enum.
  - `MUL_PP_ROWS=34`.
  - `MUL_S1_ROWS=8`.
  - `MUL_PROD_W=64`.
- Sub-module `csa_3_2`: parameterised-width 3:2 compressor, producing `s = x^y^z` and `c = maj(x,y,z)<<1`, truncated to the width. It is instantiated per Wallace level inside generate loops.
- Two pipeline stages live in the top module. There is no other sub-module.

## Test plan
- MULHU, rs1=rs2=0xFFFFFFFF → after 2 cycles, `sum_o+carry_o` = 0xFFFFFFFE_00000001, `op_o`=11.
- MULH, rs1=rs2=0xFFFFFFFF (−1·−1) → pair sum = 0x00000000_00000001. MULH, rs1=0x80000000, rs2=0x80000000 → 0x40000000_00000000.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF_00000001. MUL, rs1=7, rs2=6 → 42.
- Back-to-back: 4 ops on consecutive cycles with `ready_i=1` → 4 consecutive `valid_o` beats, in order, correct values.
- Stall: hold `ready_i=0` for 3 cycles with 2 ops in flight → `ready_o`=0, outputs stable; after release, both ops drain in order and none is lost or duplicated.
- Flush/reset: assert `flush_i` with 2 ops in flight and `valid_i`=1 → `valid_o`=0 next cycle and nothing emerges. Repeat with `rst` → all outputs at their reset values.
